jtdd_objdma: RTL and testbench
==============================

# jtdd_objdma

Object-RAM DMA scheduler for the Double Dragon video section. On each vertical-blank start it requests the main CPU bus, copies the whole CPU-written object RAM into the object shadow buffer, then releases the bus. It runs in the pixel-clock domain next to the video timing generator and takes its trigger from that generator's VBL output. Transfers never overlap active display.

## Interface
Parameters:
- AW, 9, address width; transfer length is 2^AW bytes (512).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pxl_cen  in  1  pixel clock enable; all state advances only on clk edges with pxl_cen=1
- vbl  in  1  vertical blank from the timing generator, level
- dma_en  in  1  enables triggering; sampled at the VBL rising edge only
- cpu_busreq  out  1  bus request to the CPU (halt request)
- cpu_busak  in  1  bus grant from the CPU
- src_addr  out  AW  object RAM read address
- src_dout  in  8  object RAM read data, valid one clk after src_addr
- dst_addr  out  AW  shadow buffer write address
- dst_din  out  8  shadow buffer write data
- dst_we  out  1  shadow buffer write strobe
- busy  out  1  high from request until release
- done  out  1  one-clk pulse on successful completion
- overrun  out  1  sticky error: the copy did not finish inside VBL

## Operation
- VBL rising edge: registered vbl_l, edge = vbl & ~vbl_l, both evaluated on pxl_cen.
- States:
  - IDLE
    - edge & dma_en -> REQ; cnt <= 0
    - edge & ~dma_en -> stays IDLE, no bus activity
  - REQ
    - cpu_busreq=1
    - cpu_busak=1 -> RD
    - vbl=0 -> IDLE with overrun<=1 (grant never arrived)
  - RD
    - src_addr=cnt -> WR
  - WR
    - dst_we=1, dst_addr=cnt, dst_din=src_dout captured at entry
    - cnt==2^AW-1 -> REL, otherwise cnt<=cnt+1 and -> RD
  - REL
    - cpu_busreq<=0, done pulse, overrun<=0 -> IDLE
- Abort: vbl falls in RD/WR -> IDLE immediately; busreq dropped; overrun<=1. An in-flight WR completes its current cycle.
- cpu_busak drops during RD/WR -> hold state and counter, dst_we=0, until busak returns. vbl fall still aborts.
- cnt is AW bits wide. The terminal compare uses all-ones, so the counter never wraps.
- busy = (state != IDLE).
- overrun is cleared only by a successful REL or by reset.

## Timing
- Reset values: cpu_busreq=0, src_addr=0, dst_addr=0, dst_din=0, dst_we=0, busy=0, done=0, overrun=0, state=IDLE.
- cpu_busreq is asserted on the first pxl_cen after the edge is detected. That is 2 cen ticks after vbl rises at the input.
- Throughput: one byte per 2 cen ticks. A full copy takes 1024 ticks plus the grant latency.
- dst_we is high for exactly one pxl_cen period, i.e. from one cen edge to the next.
- done is high for one clk, coincident with the pxl_cen at the end of REL.
- cpu_busreq falls at REL, one cen tick after the last write.
- If a new VBL edge arrives while not in IDLE, it is ignored.
- Reset mid-transfer drops busreq asynchronously. The shadow content is then undefined.

## Structure
- Shared include jtdd_objdma.vh holds:
  - state localparams IDLE/REQ/RD/WR/REL, 3-bit encoding
  - the derived constant LAST = 2^AW-1
- Single module; no sub-module is warranted. The edge detector and counter are inline.
- Instantiated beside jtdd_timing. vbl connects straight from that block's VBL output.

## Test plan
- Grant immediate: dma_en=1, VBL rises, busak returned 1 cen after busreq -> 512 writes, dst_din = src pattern (addr^8'h5A), done pulse, overrun=0, busreq low 1 cen after the last write.
- dma_en=0 at the VBL edge -> no busreq, no dst_we, busy stays 0 for the whole frame.
- Grant never given: busak held 0 through VBL -> busreq drops when vbl falls, overrun=1, zero writes.
- Late grant: busak after 700 cen ticks with a VBL of 1000 ticks -> abort partway through, the written count matches the cycles available, overrun=1. The next frame with a prompt grant completes and clears overrun.
- busak toggled low for 10 ticks mid-copy -> writes pause, resume at the same cnt, and the final image is complete and correct.
- Async reset asserted at cnt=100 -> all outputs go to 0 immediately. After release, the next VBL performs a clean full copy.

Source files
------------

// File: rtl/jtdd_objdma_pkg.sv
// Shared definitions for the object-RAM DMA scheduler.
//   state_t : FSM state encoding (3 bits), also visible on the debug port
//   OBJ_AW  : default object RAM address width (512-byte object table)
package jtdd_objdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REL  = 3'd4
  } state_t;

  localparam int OBJ_AW = 9;

endpackage

// File: rtl/jtdd_objdma.sv
// Object-RAM DMA scheduler for the Double Dragon video section.
// At each vertical-blank start it halts the main CPU, copies the whole
// object RAM (2^AW bytes) into the object shadow buffer, then releases the
// bus. Everything advances on clk edges qualified by pxl_cen.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pxl_cen             pixel clock enable
//   vbl                 vertical blank level from the timing generator
//   dma_en              copy enable, looked at only on the VBL rising edge
//   cpu_busreq/busak    CPU halt request / grant
//   src_addr, src_dout  object RAM read port (data one clk after address)
//   dst_addr/din/we     shadow buffer write port
//   busy                high from request until release
//   done                one-clk pulse after a complete copy
//   overrun             sticky: last copy could not finish inside VBL
//   state_dbg           current FSM state
//
// Bus handshake: cpu_busreq is a level request held for the whole transfer;
// a byte is read or written only on cen edges where cpu_busak is high. If
// the grant drops, the FSM freezes (counter held, no write) until it
// returns. Falling vbl always wins: the transfer is abandoned and flagged.
module jtdd_objdma
  import jtdd_objdma_pkg::*;
#(
  parameter int AW = OBJ_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          vbl,
  input  logic          dma_en,
  output logic          cpu_busreq,
  input  logic          cpu_busak,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_dout,
  output logic [AW-1:0] dst_addr,
  output logic [7:0]    dst_din,
  output logic          dst_we,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [2:0]    state_dbg
);

  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] cnt;
  logic          vbl_l;
  logic          vbl_edge;

  assign vbl_edge  = vbl & ~vbl_l;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      vbl_l      <= 1'b0;
      cpu_busreq <= 1'b0;
      src_addr   <= '0;
      dst_addr   <= '0;
      dst_din    <= 8'd0;
      dst_we     <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // done lasts a single clk regardless of the cen rate
      done <= 1'b0;
      if (pxl_cen) begin
        vbl_l <= vbl;
        case (state)
          ST_IDLE: begin
            if (vbl_edge && dma_en) begin
              state    <= ST_REQ;
              cnt      <= '0;
              src_addr <= '0;
            end
          end
          ST_REQ: begin
            if (!vbl) begin
              // blanking ended before the CPU granted the bus
              state      <= ST_IDLE;
              cpu_busreq <= 1'b0;
              overrun    <= 1'b1;
            end else begin
              cpu_busreq <= 1'b1;
              if (cpu_busak) state <= ST_RD;
            end
          end
          ST_RD: begin
            if (!vbl) begin
              state      <= ST_IDLE;
              cpu_busreq <= 1'b0;
              overrun    <= 1'b1;
            end else if (cpu_busak) begin
              // src_addr has been stable for the whole RD period
              dst_din <= src_dout;
              dst_addr <= cnt;
              dst_we   <= 1'b1;
              state    <= ST_WR;
            end
          end
          ST_WR: begin
            // the strobe covers exactly the one cen period spent in WR
            dst_we <= 1'b0;
            if (!vbl) begin
              state      <= ST_IDLE;
              cpu_busreq <= 1'b0;
              overrun    <= 1'b1;
            end else if (cpu_busak) begin
              if (cnt == LAST) begin
                state <= ST_REL;
              end else begin
                cnt      <= cnt + 1'b1;
                src_addr <= cnt + 1'b1;
                state    <= ST_RD;
              end
            end
          end
          ST_REL: begin
            cpu_busreq <= 1'b0;
            done       <= 1'b1;
            overrun    <= 1'b0;
            state      <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdd_objdma.sv
module tb_jtdd_objdma;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pxl_cen = 1'b0;
  logic          vbl = 1'b0;
  logic          dma_en = 1'b0;
  logic          cpu_busak = 1'b0;
  logic [7:0]    src_dout = 8'd0;
  logic          cpu_busreq;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [7:0]    dst_din;
  logic          dst_we;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [2:0]    state_dbg;

  jtdd_objdma #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pxl_cen    (pxl_cen),
    .vbl        (vbl),
    .dma_en     (dma_en),
    .cpu_busreq (cpu_busreq),
    .cpu_busak  (cpu_busak),
    .src_addr   (src_addr),
    .src_dout   (src_dout),
    .dst_addr   (dst_addr),
    .dst_din    (dst_din),
    .dst_we     (dst_we),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // object RAM model: byte at address a is a[7:0]^8'h5A, one clk latency
  always @(posedge clk) src_dout <= src_addr[7:0] ^ 8'h5A;

  // ---------------- scoreboard / monitor ----------------
  logic [AW+7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int mon_tick = 0;
  int wr_cnt = 0, done_cnt = 0, busreq_cnt = 0, busy_cnt = 0, sb_bad = 0;
  int done_tick = 0, we_tick = 0, br_rise_tick = 0, br_fall_tick = 0;
  logic br_prev = 1'b0;

  // One sample per cen period, taken at the negedge right after the cen
  // edge; cen toggles at the end of this block so it is high every 2nd clk.
  always @(negedge clk) begin
    if (pxl_cen) begin
      mon_tick++;
      if (dst_we) begin
        wr_cnt++;
        we_tick = mon_tick;
        if (exp_q.size() == 0) sb_bad++;
        else if (exp_q.pop_front() !== {dst_addr, dst_din}) sb_bad++;
      end
      if (done) begin
        done_cnt++;
        done_tick = mon_tick;
      end
      if (cpu_busreq) busreq_cnt++;
      if (busy) busy_cnt++;
      if (cpu_busreq && !br_prev) br_rise_tick = mon_tick;
      if (!cpu_busreq && br_prev) br_fall_tick = mon_tick;
      br_prev = cpu_busreq;
    end
    pxl_cen = ~pxl_cen;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // advance to just after the next cen edge (and after the monitor sample)
  task automatic tick();
    do @(posedge clk); while (!pxl_cen);
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = i[AW-1:0];
      exp_q.push_back({a, a[7:0] ^ 8'h5A});
    end
  endtask

  // One frame: vbl high for vlen ticks. busak is high from tick grant_at
  // onwards except for ticks gap_s..gap_e. Timing arguments are relative to
  // the tick at which vbl rose (tick 0); -1 means "not expected".
  task automatic frame(input string nm, input logic en, input int vlen,
                       input int grant_at, input int gap_s, input int gap_e,
                       input int exp_wr, input int exp_done, input int exp_fall,
                       input logic exp_ovr);
    int wr0, dn0, br0, by0, bad0, st;
    exp_q.delete();
    push_exp(exp_wr);
    wr0 = wr_cnt; dn0 = done_cnt; br0 = busreq_cnt; by0 = busy_cnt; bad0 = sb_bad;
    dma_en = en;
    cpu_busak = 1'b0;
    st = mon_tick;
    vbl = 1'b1;
    for (int t = 1; t <= vlen; t++) begin
      tick();
      cpu_busak = (t >= grant_at) && !(t >= gap_s && t <= gap_e);
    end
    vbl = 1'b0;
    repeat (20) tick();
    cpu_busak = 1'b0;
    check({nm, " writes"}, wr_cnt - wr0, exp_wr);
    check({nm, " data errors"}, sb_bad - bad0, 0);
    check({nm, " missing writes"}, exp_q.size(), 0);
    check({nm, " done pulses"}, done_cnt - dn0, (exp_done >= 0) ? 1 : 0);
    check({nm, " overrun"}, overrun, exp_ovr);
    check({nm, " busreq end"}, cpu_busreq, 0);
    check({nm, " busy end"}, busy, 0);
    check({nm, " busreq active"}, (busreq_cnt - br0) > 0, en);
    check({nm, " busy active"}, (busy_cnt - by0) > 0, en);
    if (exp_done >= 0) check({nm, " done tick"}, done_tick - st, exp_done);
    if (exp_fall >= 0) begin
      check({nm, " busreq rise tick"}, br_rise_tick - st, 2);
      check({nm, " busreq fall tick"}, br_fall_tick - st, exp_fall);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (4) @(negedge clk);
    #1;
    check("reset busreq", cpu_busreq, 0);
    check("reset src_addr", src_addr, 0);
    check("reset dst_addr", dst_addr, 0);
    check("reset dst_din", dst_din, 0);
    check("reset dst_we", dst_we, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset overrun", overrun, 0);
    check("reset state", state_dbg, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // prompt grant: write k at tick 4+2k, last at 1026, done/busreq fall 1028
    frame("full", 1'b1, 1100, 2, -1, -1, 512, 1028, 1028, 1'b0);
    check("full last write tick", we_tick - br_rise_tick, 1026 - 2);

    // grant never given: abort on the first tick that sees vbl low
    frame("nogrant", 1'b1, 300, 100000, -1, -1, 0, -1, 301, 1'b1);

    // disabled: no activity, overrun left as it was
    frame("disabled", 1'b0, 1100, 2, -1, -1, 0, -1, -1, 1'b1);

    // late grant at 700: writes at 702+2k up to tick 1000 -> 150 bytes
    frame("late", 1'b1, 1000, 700, -1, -1, 150, -1, 1001, 1'b1);
    frame("recover", 1'b1, 1100, 2, -1, -1, 512, 1028, 1028, 1'b0);

    // grant withdrawn for 10 ticks mid-copy: everything slips by 10 ticks
    frame("gap", 1'b1, 1100, 2, 400, 409, 512, 1038, 1038, 1'b0);

    // async reset while byte 100 is being written
    exp_q.delete();
    push_exp(101);
    dma_en = 1'b1;
    vbl = 1'b1;
    for (int t = 1; t <= 204; t++) begin
      tick();
      cpu_busak = (t >= 2);
    end
    check("pre-reset dst_we", dst_we, 1);
    check("pre-reset dst_addr", dst_addr, 100);
    rst_n = 1'b0;
    #1;
    check("midreset busreq", cpu_busreq, 0);
    check("midreset dst_we", dst_we, 0);
    check("midreset busy", busy, 0);
    check("midreset src_addr", src_addr, 0);
    check("midreset dst_addr", dst_addr, 0);
    check("midreset dst_din", dst_din, 0);
    check("midreset overrun", overrun, 0);
    check("partial writes seen", exp_q.size(), 0);
    vbl = 1'b0;
    cpu_busak = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    frame("after reset", 1'b1, 1100, 2, -1, -1, 512, 1028, 1028, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
